// File: rtl/me_search_control.sv
// me_search_control
//   Sequencer for the 16-PE full-search motion estimator. One search walks a
//   13-bit counter through 4112 busy cycles: 16 row passes of 256 cycles
//   (row pass r, column step c), plus a 16-cycle drain that delivers the
//   last row of PE results.
//   Every output is a Moore decode of the registered state and counter. The
//   only other registers are the done pulse and the held candidate vector.
//
//   Optional build macro: ME_ABORT_EN
//     When defined, an abort input is added. Asserting abort while busy
//     returns the sequencer to IDLE on the next cycle, with no done pulse.

module me_search_control #(
  parameter int PE_NUM = 16,  // the decode below assumes exactly 16 PEs
  parameter int CNT_W  = 13   // count[12:8] = row pass, count[7:0] = column step
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
`ifdef ME_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [7:0]        AddressR,
  output logic [9:0]        AddressS1,
  output logic [9:0]        AddressS2,
  output logic [PE_NUM-1:0] S1S2mux,
  output logic [PE_NUM-1:0] NewDist,
  output logic              CompStart,
  output logic [PE_NUM-1:0] PEready,
  output logic [3:0]        VectorX,
  output logic [3:0]        VectorY
);

  // The last busy count is row 16 (drain), column 15.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(4111);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             done_q;
  logic [3:0]       vec_x_q;
  logic [3:0]       vec_y_q;

  // ---------------------------------------------------------------------
  // Abort request. Without the optional feature it is tied off, so the
  // search can only be interrupted by reset.
  // ---------------------------------------------------------------------
  logic abort_req;

`ifdef ME_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Counter fields
  // ---------------------------------------------------------------------
  logic [CNT_W-9:0] row;       // r: 0..16
  logic [7:0]       col;       // c: 0..255
  logic             at_last;   // final busy cycle
  logic             row_active;// r >= 1: a PE result row is being delivered
  logic             pe_slot;   // c in 0..15: a PE finishes its candidate now
  logic             pe_valid;  // a candidate is offered to the comparator

  assign row        = count[CNT_W-1:8];
  assign col        = count[7:0];
  assign at_last    = (count == LAST_COUNT);
  assign row_active = (row != '0);
  assign pe_slot    = (col[7:4] == 4'd0);
  assign pe_valid   = row_active && pe_slot;

  // ---------------------------------------------------------------------
  // Search-window address. The row offset plus the block-row index is at
  // most 30, so the address never wraps. In the drain row r[3:0] is 0,
  // which gives a harmless in-range address.
  // Port S2 is the same row 16 columns to the right, so it only differs in
  // the 16s bit of the address.
  // ---------------------------------------------------------------------
  logic [4:0] addr_row;

  assign addr_row = {1'b0, row[3:0]} + {1'b0, col[7:4]};

  // ---------------------------------------------------------------------
  // Candidate vector of the PE finishing this cycle.
  // x = c - 8 and y = (r - 1) - 8. In 4 bits, subtracting 8 is the same as
  // flipping the sign bit.
  // ---------------------------------------------------------------------
  logic [3:0] row_m1;
  logic [3:0] live_x;
  logic [3:0] live_y;

  assign row_m1 = row[3:0] - 4'd1;
  assign live_x = {~col[3], col[2:0]};
  assign live_y = {~row_m1[3], row_m1[2:0]};

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    // NOTE: registers are assigned with <= so that every flop samples the
    // values from before the edge, whatever order the statements are in.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start is only looked at in IDLE, and it takes priority
  // over abort there. Abort or the last count ends a search.
  always_comb begin
    // NOTE: the default assignment comes first so that every path through the
    // block assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (abort_req || at_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequence counter: runs while the search stays busy, otherwise it is 0,
  // so every search starts from count 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if ((state == BUSY) && (state_next == BUSY)) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

  // Done pulse: one cycle, in the first IDLE cycle after a search that ran
  // to completion. An aborted search does not pulse done.
  always_ff @(posedge clock) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state == BUSY) && at_last && !abort_req;
    end
  end

  // Hold the most recently offered candidate vector between PEready pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      vec_x_q <= 4'd0;
      vec_y_q <= 4'd0;
    end else if ((state == BUSY) && pe_valid) begin
      vec_x_q <= live_x;
      vec_y_q <= live_y;
    end
  end

  // Output decode: everything is 0 in IDLE except the done pulse.
  always_comb begin
    busy      = 1'b0;
    done      = done_q;
    AddressR  = 8'd0;
    AddressS1 = 10'd0;
    AddressS2 = 10'd0;
    S1S2mux   = '0;
    NewDist   = '0;
    CompStart = 1'b0;
    PEready   = '0;
    VectorX   = 4'd0;
    VectorY   = 4'd0;

    if (state == BUSY) begin
      busy      = 1'b1;
      AddressR  = col;
      AddressS1 = {addr_row, 1'b0, col[3:0]};
      AddressS2 = {addr_row, 1'b1, col[3:0]};
      // The comparator keeps BestDist cleared for all of row pass 0, while
      // no PE has a finished result yet.
      CompStart = row_active;

      for (int i = 0; i < PE_NUM; i++) begin
        // PE i takes port S1 data once the column step has reached it.
        S1S2mux[i] = (col[3:0] >= 4'(i));
        // PE i starts a new accumulation at column step i of every pass.
        NewDist[i] = (col == 8'(i));
        // That same step is when PE i finished the previous row's candidate.
        PEready[i] = pe_valid && (col[3:0] == 4'(i));
      end

      if (pe_valid) begin
        VectorX = live_x;
        VectorY = live_y;
      end else begin
        VectorX = vec_x_q;
        VectorY = vec_y_q;
      end
    end
  end

endmodule

// File: tb/tb_me_search_control.sv
// tb_me_search_control
//   Directed bench for me_search_control. Each scenario task drives its own
//   stimulus and compares outputs against hand-computed values. Define
//   ME_ABORT_EN for both bench and RTL to run the abort scenario as well.

module tb_me_search_control;

  logic        clock;
  logic        reset;
  logic        start;
`ifdef ME_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic        done;
  logic [7:0]  AddressR;
  logic [9:0]  AddressS1;
  logic [9:0]  AddressS2;
  logic [15:0] S1S2mux;
  logic [15:0] NewDist;
  logic        CompStart;
  logic [15:0] PEready;
  logic [3:0]  VectorX;
  logic [3:0]  VectorY;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt   = 0;  // count the DUT should be showing in the current search

  me_search_control dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
`ifdef ME_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .S1S2mux   (S1S2mux),
    .NewDist   (NewDist),
    .CompStart (CompStart),
    .PEready   (PEready),
    .VectorX   (VectorX),
    .VectorY   (VectorY)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulse start for one cycle; afterwards the DUT should be at count 0.
  task automatic start_search();
    start = 1'b1;
    step();
    start = 1'b0;
    cnt   = 0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL start_busy: got %b want 1", busy);
    end
  endtask

  // Advance the running search up to the given count.
  task automatic run_to(input int target);
    while (cnt < target) begin
      step();
      cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
`ifdef ME_ABORT_EN
    abort = 1'b0;
`endif
    step();
    step();
    n_cmp++;
    if ({busy, done, CompStart, PEready, NewDist, S1S2mux, AddressR,
         AddressS1, AddressS2, VectorX, VectorY} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b cs=%b pe=%h nd=%h mux=%h ar=%h s1=%h s2=%h vx=%h vy=%h want all 0",
               busy, done, CompStart, PEready, NewDist, S1S2mux, AddressR,
               AddressS1, AddressS2, VectorX, VectorY);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  // One complete search with spot checks; ends on the done cycle.
  task automatic test_full_search();
    int pulses  = 0;
    int pe_err  = 0;
    int cs_err  = 0;
    int oh_err  = 0;
    int bsy_err = 0;
    logic [15:0] pe_exp;

    start_search();
    for (int k = 0; k <= 4111; k++) begin
      pe_exp = ((k >= 256) && ((k % 256) < 16)) ? (16'h0001 << (k % 16)) : 16'h0000;
      if (PEready !== pe_exp) pe_err++;
      if (CompStart !== (k >= 256)) cs_err++;
      if (PEready !== 16'h0000) begin
        pulses++;
        if ((PEready & (PEready - 16'h0001)) !== 16'h0000) oh_err++;
      end
      if ((busy !== 1'b1) || (done !== 1'b0)) bsy_err++;

      if (k == 3) begin
        n_cmp++;
        if ({NewDist, S1S2mux, AddressR, AddressS1, AddressS2} !==
            {16'h0008, 16'h000F, 8'd3, 10'd3, 10'd19}) begin
          n_bad++;
          $display("FAIL count3_decode: got nd=%h mux=%h ar=%0d s1=%0d s2=%0d want nd=0008 mux=000f ar=3 s1=3 s2=19",
                   NewDist, S1S2mux, AddressR, AddressS1, AddressS2);
        end
      end
      if (k == 256) begin
        n_cmp++;
        if ({PEready, VectorX, VectorY, CompStart} !== {16'h0001, 4'h8, 4'h8, 1'b1}) begin
          n_bad++;
          $display("FAIL first_result: got pe=%h vx=%h vy=%h cs=%b want pe=0001 vx=8 vy=8 cs=1",
                   PEready, VectorX, VectorY, CompStart);
        end
      end
      if (k == 257) begin
        n_cmp++;
        if ({PEready, VectorX, VectorY} !== {16'h0002, 4'h9, 4'h8}) begin
          n_bad++;
          $display("FAIL second_result: got pe=%h vx=%h vy=%h want pe=0002 vx=9 vy=8",
                   PEready, VectorX, VectorY);
        end
      end
      if (k == 272) begin
        n_cmp++;
        if ({PEready, NewDist, S1S2mux, VectorX, VectorY} !==
            {16'h0000, 16'h0000, 16'h0001, 4'h7, 4'h8}) begin
          n_bad++;
          $display("FAIL vector_hold: got pe=%h nd=%h mux=%h vx=%h vy=%h want pe=0 nd=0 mux=0001 vx=7 vy=8",
                   PEready, NewDist, S1S2mux, VectorX, VectorY);
        end
      end
      if (k == 'h2A5) begin
        n_cmp++;
        if ({AddressR, AddressS1, AddressS2} !== {8'hA5, 10'd389, 10'd405}) begin
          n_bad++;
          $display("FAIL addr_2a5: got ar=%h s1=%0d s2=%0d want ar=a5 s1=389 s2=405",
                   AddressR, AddressS1, AddressS2);
        end
        n_cmp++;
        if ({S1S2mux, NewDist} !== {16'h003F, 16'h0000}) begin
          n_bad++;
          $display("FAIL mux_2a5: got mux=%h nd=%h want mux=003f nd=0000", S1S2mux, NewDist);
        end
      end
      if (k == 4095) begin
        n_cmp++;
        if ({AddressR, AddressS1, AddressS2} !== {8'hFF, 10'd975, 10'd991}) begin
          n_bad++;
          $display("FAIL addr_max: got ar=%h s1=%0d s2=%0d want ar=ff s1=975 s2=991",
                   AddressR, AddressS1, AddressS2);
        end
      end
      if (k == 4111) begin
        n_cmp++;
        if ({PEready, VectorX, VectorY, AddressS1, AddressS2} !==
            {16'h8000, 4'h7, 4'h7, 10'd15, 10'd31}) begin
          n_bad++;
          $display("FAIL last_result: got pe=%h vx=%h vy=%h s1=%0d s2=%0d want pe=8000 vx=7 vy=7 s1=15 s2=31",
                   PEready, VectorX, VectorY, AddressS1, AddressS2);
        end
      end

      // A start pulse in the middle of a search must be ignored.
      start = (k == 100);
      if (k < 4111) begin
        step();
        cnt++;
      end
    end
    start = 1'b0;

    n_cmp++;
    if (pe_err != 0) begin
      n_bad++;
      $display("FAIL pe_sequence: got %0d wrong cycles want 0", pe_err);
    end
    n_cmp++;
    if (cs_err != 0) begin
      n_bad++;
      $display("FAIL compstart_sequence: got %0d wrong cycles want 0", cs_err);
    end
    n_cmp++;
    if ((pulses != 256) || (oh_err != 0)) begin
      n_bad++;
      $display("FAIL pe_pulses: got %0d pulses %0d non-onehot want 256 pulses 0 non-onehot",
               pulses, oh_err);
    end
    n_cmp++;
    if (bsy_err != 0) begin
      n_bad++;
      $display("FAIL busy_window: got %0d cycles with busy low or done high want 0", bsy_err);
    end

    // 4112 cycles after busy rose: IDLE with a done pulse.
    step();
    n_cmp++;
    if ({busy, done, CompStart, PEready} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL done_pulse: got busy=%b done=%b cs=%b pe=%h want busy=0 done=1 cs=0 pe=0000",
               busy, done, CompStart, PEready);
    end
  endtask

  // Start on the done cycle begins a new search straight away.
  task automatic test_back_to_back();
    start_search();
    n_cmp++;
    if ({done, CompStart, NewDist, AddressR, PEready} !==
        {1'b0, 1'b0, 16'h0001, 8'd0, 16'h0000}) begin
      n_bad++;
      $display("FAIL back_to_back: got done=%b cs=%b nd=%h ar=%h pe=%h want done=0 cs=0 nd=0001 ar=0 pe=0",
               done, CompStart, NewDist, AddressR, PEready);
    end
  endtask

  // Reset in the middle of a search, then a clean restart from count 0.
  task automatic test_reset_mid_search();
    run_to(1000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({busy, done, CompStart, PEready, NewDist, S1S2mux, AddressR,
         AddressS1, AddressS2, VectorX, VectorY} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b done=%b cs=%b pe=%h nd=%h mux=%h ar=%h s1=%h s2=%h vx=%h vy=%h want all 0",
               busy, done, CompStart, PEready, NewDist, S1S2mux, AddressR,
               AddressS1, AddressS2, VectorX, VectorY);
    end
    step();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_mid_reset: got busy=%b done=%b want 0 0", busy, done);
    end

    start_search();
    n_cmp++;
    if ({CompStart, NewDist, AddressR} !== {1'b0, 16'h0001, 8'd0}) begin
      n_bad++;
      $display("FAIL restart_count0: got cs=%b nd=%h ar=%h want cs=0 nd=0001 ar=0",
               CompStart, NewDist, AddressR);
    end
    run_to(255);
    n_cmp++;
    if (CompStart !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_cs_255: got %b want 0", CompStart);
    end
    run_to(256);
    n_cmp++;
    if ({CompStart, PEready} !== {1'b1, 16'h0001}) begin
      n_bad++;
      $display("FAIL restart_first_result: got cs=%b pe=%h want cs=1 pe=0001", CompStart, PEready);
    end

    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

`ifdef ME_ABORT_EN
  task automatic test_abort();
    int done_seen = 0;

    start_search();
    run_to(2000);
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if ({busy, done, CompStart, PEready, NewDist} !== '0) begin
      n_bad++;
      $display("FAIL abort_stop: got busy=%b done=%b cs=%b pe=%h nd=%h want all 0",
               busy, done, CompStart, PEready, NewDist);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if ((done !== 1'b0) || (busy !== 1'b0)) done_seen++;
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d bad idle cycles want 0", done_seen);
    end

    // start and abort together in IDLE: start wins.
    abort = 1'b1;
    start_search();
    abort = 1'b0;
    n_cmp++;
    if ({AddressR, CompStart, NewDist} !== {8'd0, 1'b0, 16'h0001}) begin
      n_bad++;
      $display("FAIL start_over_abort: got ar=%h cs=%b nd=%h want ar=0 cs=0 nd=0001",
               AddressR, CompStart, NewDist);
    end
    run_to(4111);
    n_cmp++;
    if ({busy, PEready} !== {1'b1, 16'h8000}) begin
      n_bad++;
      $display("FAIL post_abort_last: got busy=%b pe=%h want busy=1 pe=8000", busy, PEready);
    end
    step();
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_bad++;
      $display("FAIL post_abort_done: got busy=%b done=%b want 0 1", busy, done);
    end
    step();
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
`ifdef ME_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_full_search();
    test_back_to_back();
    test_reset_mid_search();
`ifdef ME_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
